bram_clk_phase_gen: RTL and testbench

- Clock-generation leaf that derives the BRAM-port clock from the AXI fabric clock.
- Default configuration: undivided copy of S_AXI_ACLK shifted by 180 degrees, so BRAM samples address/data mid-cycle of the logic that drives them.
- Stands in for the vendor clock wizard in simulation and in builds without an MMCM.
- Provides a lock-status flag for consumers that need one.

---
 rtl/bram_clk_phase_gen.sv | 98 +++++++++
 tb/tb_bram_clk_phase_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/bram_clk_phase_gen.sv
// BRAM-port clock generator: phase-shifted or divided copy of S_AXI_ACLK
// with a saturating lock-status counter.
module bram_clk_phase_gen #(
    parameter int PHASE_180   = 1,
    parameter int DIVIDE      = 1,
    parameter int LOCK_CYCLES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic S_AXI_ACLK,
    input  logic reset,
    output logic clk_out1,
    output logic locked
);

    localparam logic                 PHASE_BIT = (PHASE_180 != 0);
    localparam logic [CNT_WIDTH-1:0] LOCK_MAX  = CNT_WIDTH'(LOCK_CYCLES);

    generate
        if (!(DIVIDE == 1 || (DIVIDE >= 2 && (DIVIDE % 2) == 0))) begin : g_bad_divide
            $error("bram_clk_phase_gen: DIVIDE must be 1 or an even integer >= 2");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("bram_clk_phase_gen: LOCK_CYCLES must be >= 1");
        end
        if (PHASE_180 != 0 && PHASE_180 != 1) begin : g_bad_phase
            $error("bram_clk_phase_gen: PHASE_180 must be 0 or 1");
        end
        if (CNT_WIDTH < 1 || (LOCK_CYCLES >> CNT_WIDTH) != 0 || ((DIVIDE / 2) >> CNT_WIDTH) != 0) begin : g_bad_width
            $error("bram_clk_phase_gen: CNT_WIDTH too small for DIVIDE/2 or LOCK_CYCLES");
        end
    endgenerate

    // Lock counter saturates at LOCK_CYCLES so it can never wrap and drop locked.
    logic [CNT_WIDTH-1:0] lock_cnt_q = '0;
    logic [CNT_WIDTH-1:0] lock_cnt_d;
    logic                 locked_q   = 1'b0;
    logic                 locked_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + CNT_WIDTH'(1);
        end
        if (lock_cnt_d == LOCK_MAX) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

    generate
        if (DIVIDE >= 2) begin : g_div
            localparam logic [CNT_WIDTH-1:0] HALF_M1 = CNT_WIDTH'(DIVIDE / 2 - 1);

            logic                 div_q     = 1'b0;
            logic                 div_d;
            logic [CNT_WIDTH-1:0] div_cnt_q = '0;
            logic [CNT_WIDTH-1:0] div_cnt_d;

            always_comb begin
                div_d     = div_q;
                div_cnt_d = div_cnt_q + CNT_WIDTH'(1);
                if (div_cnt_q == HALF_M1) begin
                    div_cnt_d = '0;
                    div_d     = ~div_q;
                end
            end

            always_ff @(posedge S_AXI_ACLK) begin
                if (reset) begin
                    div_q     <= 1'b0;
                    div_cnt_q <= '0;
                end else begin
                    div_q     <= div_d;
                    div_cnt_q <= div_cnt_d;
                end
            end

            // Reset parks div_q at 0, so the output rests at the phase constant.
            assign clk_out1 = div_q ^ PHASE_BIT;
        end else begin : g_bypass
            // Pure wire path: free-running even during reset, no register latency.
            assign clk_out1 = PHASE_BIT ? ~S_AXI_ACLK : S_AXI_ACLK;
        end
    endgenerate

endmodule

// File: tb/tb_bram_clk_phase_gen.sv
// Bench for bram_clk_phase_gen: several parameterisations share one clock and
// reset; expectations come from an edges-since-release reference model.
module tb_bram_clk_phase_gen;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic c_d1p1, l_d1p1;
    logic c_d1p0, l_d1p0;
    logic c_d4p1, l_d4p1;
    logic c_d2p0, l_d2p0;
    logic c_l1,   l_l1;

    int  total = 0;
    int  bad   = 0;
    int  n     = 0;      // rising edges with reset low since the last reset edge
    time t_rise = 0;

    always #5 clk = ~clk;

    always @(posedge c_d1p1) t_rise = $time;

    bram_clk_phase_gen #(.PHASE_180(1), .DIVIDE(1), .LOCK_CYCLES(16), .CNT_WIDTH(16)) u_d1p1 (
        .S_AXI_ACLK(clk), .reset(reset), .clk_out1(c_d1p1), .locked(l_d1p1));
    bram_clk_phase_gen #(.PHASE_180(0), .DIVIDE(1), .LOCK_CYCLES(16), .CNT_WIDTH(16)) u_d1p0 (
        .S_AXI_ACLK(clk), .reset(reset), .clk_out1(c_d1p0), .locked(l_d1p0));
    bram_clk_phase_gen #(.PHASE_180(1), .DIVIDE(4), .LOCK_CYCLES(5), .CNT_WIDTH(8)) u_d4p1 (
        .S_AXI_ACLK(clk), .reset(reset), .clk_out1(c_d4p1), .locked(l_d4p1));
    bram_clk_phase_gen #(.PHASE_180(0), .DIVIDE(2), .LOCK_CYCLES(16), .CNT_WIDTH(16)) u_d2p0 (
        .S_AXI_ACLK(clk), .reset(reset), .clk_out1(c_d2p0), .locked(l_d2p0));
    bram_clk_phase_gen #(.PHASE_180(1), .DIVIDE(6), .LOCK_CYCLES(1), .CNT_WIDTH(4)) u_l1 (
        .S_AXI_ACLK(clk), .reset(reset), .clk_out1(c_l1), .locked(l_l1));

    function automatic logic exp_lock(int edges, int lock_cycles);
        return (edges >= lock_cycles);
    endfunction

    // Divided clock: output level flips every DIVIDE/2 edges after release.
    function automatic logic exp_div(int edges, int divide, logic phase);
        logic lvl;
        lvl = (((edges / (divide / 2)) % 2) != 0);
        return lvl ^ phase;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b n=%0d t=%0t", tag, obs, exp, n, $time);
        end
    endtask

    task automatic chkt(input string tag, input time obs, input time exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0t expected=%0t", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic lvl;
        @(posedge clk);
        n = reset ? 0 : n + 1;
        #1;
        lvl = 1'b1;
        chk1("lock_d1p1", l_d1p1, exp_lock(n, 16));
        chk1("lock_d1p0", l_d1p0, exp_lock(n, 16));
        chk1("lock_d4p1", l_d4p1, exp_lock(n, 5));
        chk1("lock_d2p0", l_d2p0, exp_lock(n, 16));
        chk1("lock_l1",   l_l1,   exp_lock(n, 1));
        chk1("clk_d4p1",  c_d4p1, exp_div(n, 4, 1'b1));
        chk1("clk_d2p0",  c_d2p0, exp_div(n, 2, 1'b0));
        chk1("clk_l1",    c_l1,   exp_div(n, 6, 1'b1));
        chk1("clk_d1p1_hi", c_d1p1, ~lvl);
        chk1("clk_d1p0_hi", c_d1p0, lvl);
        @(negedge clk);
        #1;
        lvl = 1'b0;
        chk1("clk_d1p1_lo", c_d1p1, ~lvl);
        chk1("clk_d1p0_lo", c_d1p0, lvl);
        chk1("clk_d4p1_mid", c_d4p1, exp_div(n, 4, 1'b1));
        chkt("rise_d1p1", t_rise, $time - 1);
    endtask

    initial begin
        // Power-up reset held for three edges.
        reset = 1'b1;
        repeat (3) step();

        // Release: lock rises after 16 edges and must hold for 100 more.
        reset = 1'b0;
        repeat (116) step();

        // Single-edge reset pulse after lock.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (20) step();

        // Randomised reset pulses and run lengths.
        for (int r = 0; r < 12; r++) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            reset = 1'b0;
            repeat ($urandom_range(1, 40)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
